// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: memory read port 0 plus the downstream pipeline handshake.
interface fetch_unit_if;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    // Fetch unit side
    modport slave (
        output mem_raddr,
        output out_valid,
        output out_inst,
        output out_pc,
        input  mem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc
    );

    // Memory / pipeline side
    modport master (
        input  mem_raddr,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output mem_rdata,
        output stall,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential reads to a fixed 2-cycle-latency
// memory port, tags them through a 2-stage pipeline and buffers returned words
// in an in-order queue. Issue is credit-based so returning data always has a slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          r_q [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pc;
    logic            r_t1_valid;
    logic [31:0]     r_t1_pc;
    logic            r_t2_valid;
    logic [31:0]     r_t2_pc;

    logic [SW-1:0]   w_occupancy;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    entry_t          w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check counts queued words plus both in-flight tags; a same-cycle pop earns nothing.
    assign w_occupancy = SW'(r_count) + SW'(r_t1_valid) + SW'(r_t2_valid);
    assign w_issue     = (w_occupancy < SW'(DEPTH));
    assign w_push      = r_t2_valid;
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && !bus.stall;
    assign w_head      = r_q[r_rd_ptr];

    assign bus.mem_raddr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_inst  = w_valid ? w_head.inst : 32'h0;
    assign bus.out_pc    = w_valid ? w_head.pc   : 32'h0;

    // Fetch PC and read-tag pipeline; redirect squashes both tags and reloads the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_t1_valid <= 1'b0;
            r_t1_pc    <= '0;
            r_t2_valid <= 1'b0;
            r_t2_pc    <= '0;
        end else if (bus.redirect) begin
            r_pc       <= bus.redirect_pc;
            r_t1_valid <= 1'b0;
            r_t2_valid <= 1'b0;
        end else begin
            r_t1_valid <= w_issue;
            r_t1_pc    <= r_pc;
            r_t2_valid <= r_t1_valid;
            r_t2_pc    <= r_t1_pc;
            if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // Return-queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage pairs returning data with the tag that requested it.
    always_ff @(posedge clk) begin
        if (w_push && !bus.redirect) begin
            r_q[r_wr_ptr] <= {r_t2_pc, bus.mem_rdata};
        end
    end

    // The credit rule must keep returning data from ever landing on a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus loads expected fetch streams,
// monitors pop and compare every word consumed downstream.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Memory contents: ram[i] = 0x1000_0000 + i (word index)
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Two-cycle read latency memory models
    logic [31:0] m1, m2, n1, n2;
    always @(posedge clk) begin
        m1 <= ram_word(bus.mem_raddr);
        m2 <= m1;
        n1 <= ram_word(bus2.mem_raddr);
        n2 <= n1;
    end
    assign bus.mem_rdata  = m2;
    assign bus2.mem_rdata = n2;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Replace the expected stream with sequential fetches starting at start_pc
    task automatic load_exp(input logic [31:0] start_pc);
        logic [31:0] p;
        exp_q.delete();
        p = start_pc;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({p, ram_word(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for main DUT: every consumed word must be the next expected one
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && bus.out_valid && !bus.stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h, expected no output", bus.out_pc);
            end else begin
                e = exp_q.pop_front();
                check32("sb_pc", bus.out_pc, e.pc);
                check32("sb_inst", bus.out_inst, e.inst);
            end
        end
    end

    // Monitor for wrap-around DUT: checks its first four words only
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst2_n && bus2.out_valid && exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            check32("wrap_pc", bus2.out_pc, e.pc);
            check32("wrap_inst", bus2.out_inst, e.inst);
        end
    end

    initial begin
        logic found;
        rst_n           = 1'b0;
        rst2_n          = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus2.stall       = 1'b0;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("rst_valid", 32'(bus.out_valid), 32'd0);
        check32("rst_pc", bus.out_pc, 32'h0);
        check32("rst_inst", bus.out_inst, 32'h0);
        check32("rst_raddr", bus.mem_raddr, 32'h0);
        check32("rst2_raddr", bus2.mem_raddr, 32'hFFFF_FFF8);

        load_exp(32'h0);
        exp2_q.push_back({32'hFFFF_FFF8, 32'h4FFF_FFFE});
        exp2_q.push_back({32'hFFFF_FFFC, 32'h4FFF_FFFF});
        exp2_q.push_back({32'h0000_0000, 32'h1000_0000});
        exp2_q.push_back({32'h0000_0004, 32'h1000_0001});
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // First word appears after the third edge
        step(); check32("e0_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("e1_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("e2_valid", 32'(bus.out_valid), 32'd1);
        check32("e2_pc", bus.out_pc, 32'h0);
        check32("e2_inst", bus.out_inst, 32'h1000_0000);
        for (int i = 0; i < 20; i++) begin
            step();
            check32("no_gap", 32'(bus.out_valid), 32'd1);
        end

        // Restart at 0, then stall for 10 cycles while the head is pc 8
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect = 1'b0;
        load_exp(32'h0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (bus.out_valid && bus.out_pc == 32'h8) found = 1'b1;
        end
        check32("find_pc8", 32'(found), 32'd1);
        bus.stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check32("stall_pc", bus.out_pc, 32'h8);
            check32("stall_raddr", bus.mem_raddr, 32'h18);
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check32("post_stall_valid", 32'(bus.out_valid), 32'd1);
        end

        // Build 2 queued + 2 in flight, then redirect to 0x100
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        bus.stall       = 1'b1;
        step();
        bus.redirect = 1'b0;
        load_exp(32'h200);
        repeat (4) step();
        check32("two_q_valid", 32'(bus.out_valid), 32'd1);
        check32("two_q_pc", bus.out_pc, 32'h200);
        check32("two_q_raddr", bus.mem_raddr, 32'h210);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.stall       = 1'b0;
        step();
        bus.redirect = 1'b0;
        load_exp(32'h100);
        check32("redir_r1_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("redir_r2_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("redir_r3_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("redir_r4_valid", 32'(bus.out_valid), 32'd1);
        check32("redir_pc", bus.out_pc, 32'h100);
        check32("redir_inst", bus.out_inst, 32'h1000_0040);
        repeat (6) step();

        // Redirect and stall together with a full queue
        bus.stall = 1'b1;
        repeat (6) step();
        check32("full_valid", 32'(bus.out_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect = 1'b0;
        load_exp(32'h300);
        check32("rs_valid", 32'(bus.out_valid), 32'd0);
        check32("rs_raddr", bus.mem_raddr, 32'h300);
        step();
        check32("rs_raddr2", bus.mem_raddr, 32'h304);
        bus.stall = 1'b0;
        step();
        step();
        check32("rs_out_valid", 32'(bus.out_valid), 32'd1);
        check32("rs_out_pc", bus.out_pc, 32'h300);
        repeat (6) step();

        // Asynchronous reset mid-stream with reads in flight
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("arst_valid", 32'(bus.out_valid), 32'd0);
        check32("arst_pc", bus.out_pc, 32'h0);
        check32("arst_inst", bus.out_inst, 32'h0);
        check32("arst_raddr", bus.mem_raddr, 32'h0);
        load_exp(32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(); check32("arst_e0_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("arst_e1_valid", 32'(bus.out_valid), 32'd0);
        step(); check32("arst_e2_valid", 32'(bus.out_valid), 32'd1);
        check32("arst_e2_pc", bus.out_pc, 32'h0);
        check32("arst_e2_inst", bus.out_inst, 32'h1000_0000);
        repeat (8) step();

        check32("wrap_all_seen", 32'(exp2_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
